xtea_keystream_gen: RTL and testbench

- Parametrised successor to the single-stream hash generator: a counter-mode XTEA keystream engine feeding the stream cipher's encryption block.
- Each 64-bit block is E_key({nonce, ctr}), with ctr incrementing per block. Finished blocks go into a prefetch FIFO, and the consumer drains them OUT_BYTES at a time over a valid/ready request handshake.
- Adds a configurable unroll factor, output width, prefetch depth, explicit nonce and counter-wrap reporting.

---
 rtl/xtea_keystream_gen.sv | 190 +++++++++++++++++++
 tb/tb_xtea_keystream_gen.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xtea_keystream_gen.sv
// Counter-mode XTEA keystream engine: encrypts {nonce, ctr} per block into a small
// prefetch FIFO that a consumer drains OUT_BYTES at a time over a valid/ready request.
module xtea_keystream_gen #(
   parameter int XTEA_CYCLES    = 32,
   parameter int CYCLES_PER_CLK = 1,
   parameter int OUT_BYTES      = 1,
   parameter int PREFETCH_DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   nrst,
   input  logic                   restart,
   input  logic [31:0]            nonce,
   input  logic [127:0]           key,
   input  logic                   req_valid,
   output logic                   req_ready,
   output logic                   ks_valid,
   output logic [8*OUT_BYTES-1:0] ks_data,
   output logic [31:0]            blocks_done,
   output logic                   ctr_wrapped,
   output logic                   busy
);

   localparam int ROUND_CLKS = XTEA_CYCLES / CYCLES_PER_CLK;
   localparam int RW = (ROUND_CLKS > 1) ? $clog2(ROUND_CLKS) : 1;
   localparam int PW = (PREFETCH_DEPTH > 1) ? $clog2(PREFETCH_DEPTH) : 1;
   localparam int CW = $clog2(PREFETCH_DEPTH + 1);
   localparam logic [31:0] DELTA = 32'h9E37_79B9;
   localparam logic [3:0] OB4 = 4'(OUT_BYTES);

   if ((XTEA_CYCLES % CYCLES_PER_CLK) != 0 || (8 % OUT_BYTES) != 0 ||
       PREFETCH_DEPTH < 1 || PREFETCH_DEPTH > 4) begin : g_bad_params
      $error("xtea_keystream_gen: illegal parameter combination");
   end

   typedef enum logic [1:0] {IDLE, INIT, ROUND, WRITE} state_t;
   state_t state_reg, state_next;

   logic [31:0]   v0_reg, v1_reg, sum_reg, ctr_reg, nonce_reg, blocks_reg;
   logic [127:0]  key_reg;
   logic [RW-1:0] rnd_reg;
   logic          wrapped_reg;

   logic [63:0]   fifo_mem [PREFETCH_DEPTH];
   logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic [2:0]    offset_reg;
   logic          ks_valid_reg;
   logic [8*OUT_BYTES-1:0] ks_data_reg, ks_data_next;

   logic [31:0] key_words [4];
   logic [31:0] v0_next, v1_next, sum_next;
   logic        push, xfer, pop;
   logic [3:0]  offset_sum;
   logic [63:0] head;

   for (genvar gi = 0; gi < 4; gi++) begin : g_key_words
      assign key_words[gi] = key_reg[32*gi +: 32];
   end

   // CYCLES_PER_CLK full XTEA cycles chained combinationally each clock.
   always_comb begin
      v0_next  = v0_reg;
      v1_next  = v1_reg;
      sum_next = sum_reg;
      for (int i = 0; i < CYCLES_PER_CLK; i++) begin
         v0_next  = v0_next + ((((v1_next << 4) ^ (v1_next >> 5)) + v1_next) ^
                               (sum_next + key_words[sum_next[1:0]]));
         sum_next = sum_next + DELTA;
         v1_next  = v1_next + ((((v0_next << 4) ^ (v0_next >> 5)) + v0_next) ^
                               (sum_next + key_words[sum_next[12:11]]));
      end
   end

   // IDLE looks at the registered count, so a head popping this edge still reads as full.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (int'(count_reg) < PREFETCH_DEPTH) state_next = INIT;
         INIT:    state_next = ROUND;
         ROUND:   if (rnd_reg == RW'(ROUND_CLKS - 1)) state_next = WRITE;
         WRITE:   state_next = (int'(count_reg) + 1 < PREFETCH_DEPTH) ? INIT : IDLE;
         default: state_next = IDLE;
      endcase
      if (restart) state_next = INIT;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         v0_reg  <= '0;
         v1_reg  <= '0;
         sum_reg <= '0;
         key_reg <= '0;
         rnd_reg <= '0;
      end else begin
         case (state_reg)
            INIT: begin
               v0_reg  <= nonce_reg;
               v1_reg  <= ctr_reg;
               sum_reg <= '0;
               key_reg <= key;
               rnd_reg <= '0;
            end
            ROUND: begin
               v0_reg  <= v0_next;
               v1_reg  <= v1_next;
               sum_reg <= sum_next;
               rnd_reg <= rnd_reg + RW'(1);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         ctr_reg     <= '0;
         blocks_reg  <= '0;
         wrapped_reg <= 1'b0;
         nonce_reg   <= '0;
      end else if (restart) begin
         ctr_reg     <= '0;
         blocks_reg  <= '0;
         wrapped_reg <= 1'b0;
         nonce_reg   <= nonce;
      end else if (state_reg == WRITE) begin
         ctr_reg    <= ctr_reg + 32'd1;
         blocks_reg <= blocks_reg + 32'd1;
         if (ctr_reg == 32'hFFFF_FFFF) wrapped_reg <= 1'b1;
      end
   end

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(PREFETCH_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign push       = (state_reg == WRITE) && !restart;
   assign xfer       = req_valid && req_ready && !restart;
   assign offset_sum = {1'b0, offset_reg} + OB4;
   assign pop        = xfer && (offset_sum == 4'd8);
   assign head       = fifo_mem[rd_ptr_reg];

   always_comb begin
      ks_data_next = head[{offset_reg, 3'b000} +: 8*OUT_BYTES];
   end

   // Storage kept reset-free so it can map onto RAM.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_reg] <= {v0_reg, v1_reg};
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         offset_reg   <= '0;
         ks_valid_reg <= 1'b0;
         ks_data_reg  <= '0;
      end else if (restart) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         offset_reg   <= '0;
         ks_valid_reg <= 1'b0;
      end else begin
         ks_valid_reg <= xfer;
         if (xfer) begin
            ks_data_reg <= ks_data_next;
            offset_reg  <= pop ? 3'd0 : offset_sum[2:0];
         end
         if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         if (push && !pop)      count_reg <= count_reg + CW'(1);
         else if (!push && pop) count_reg <= count_reg - CW'(1);
      end
   end

   assign req_ready   = (count_reg != '0);
   assign ks_valid    = ks_valid_reg;
   assign ks_data     = ks_data_reg;
   assign blocks_done = blocks_reg;
   assign ctr_wrapped = wrapped_reg;
   assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_xtea_keystream_gen.sv
// Scoreboard bench for xtea_keystream_gen: two instances (1-byte/depth-2 and
// 4-byte/4-cycle/depth-1), expected keystream from a reference XTEA model.
module tb_xtea_keystream_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         nrst = 1'b0;
   logic         restart_a = 1'b0, req_valid_a = 1'b0, restart_b = 1'b0, req_valid_b = 1'b0;
   logic [31:0]  nonce_a = '0, nonce_b = '0;
   logic [127:0] key_a = '0, key_b = '0;
   logic         req_ready_a, ks_valid_a, ctr_wrapped_a, busy_a;
   logic         req_ready_b, ks_valid_b, ctr_wrapped_b, busy_b;
   logic [7:0]   ks_data_a;
   logic [31:0]  ks_data_b;
   logic [31:0]  blocks_done_a, blocks_done_b;

   xtea_keystream_gen dut_a (
      .clk(clk), .nrst(nrst), .restart(restart_a), .nonce(nonce_a), .key(key_a),
      .req_valid(req_valid_a), .req_ready(req_ready_a), .ks_valid(ks_valid_a),
      .ks_data(ks_data_a), .blocks_done(blocks_done_a), .ctr_wrapped(ctr_wrapped_a),
      .busy(busy_a)
   );

   xtea_keystream_gen #(
      .XTEA_CYCLES(32), .CYCLES_PER_CLK(4), .OUT_BYTES(4), .PREFETCH_DEPTH(1)
   ) dut_b (
      .clk(clk), .nrst(nrst), .restart(restart_b), .nonce(nonce_b), .key(key_b),
      .req_valid(req_valid_b), .req_ready(req_ready_b), .ks_valid(ks_valid_b),
      .ks_data(ks_data_b), .blocks_done(blocks_done_b), .ctr_wrapped(ctr_wrapped_b),
      .busy(busy_b)
   );

   int n_cmp = 0;
   int n_bad = 0;
   logic [63:0]  q_a[$];
   logic [63:0]  q_b[$];
   logic [31:0]  m_nonce [2];
   logic [31:0]  m_blk [2];
   logic [127:0] m_key [2];
   int           m_off [2];
   logic [63:0]  last_exp [2];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] xtea_blk(input logic [31:0] n, input logic [31:0] c,
                                            input logic [127:0] k);
      logic [31:0] y, z, s;
      logic [31:0] kw [4];
      y = n;
      z = c;
      s = 32'd0;
      for (int i = 0; i < 4; i++) kw[i] = k[32*i +: 32];
      for (int i = 0; i < 32; i++) begin
         y = y + ((((z << 4) ^ (z >> 5)) + z) ^ (s + kw[s[1:0]]));
         s = s + 32'h9E37_79B9;
         z = z + ((((y << 4) ^ (y >> 5)) + y) ^ (s + kw[s[12:11]]));
      end
      return {y, z};
   endfunction

   task automatic next_exp(input int w, output logic [63:0] e);
      logic [63:0] blk;
      int ob;
      ob  = (w == 0) ? 1 : 4;
      blk = xtea_blk(m_nonce[w], m_blk[w], m_key[w]);
      e   = (blk >> (8 * m_off[w])) & ((64'd1 << (8 * ob)) - 64'd1);
      m_off[w] += ob;
      if (m_off[w] == 8) begin
         m_off[w] = 0;
         m_blk[w] = m_blk[w] + 32'd1;
      end
   endtask

   // One clock: drive at negedge, predict, then check the response at the next negedge.
   task automatic cyc(input int w, input bit rv, input bit rs, output bit xfer);
      logic [63:0] e, got;
      bit vld;
      e = '0;
      if (w == 0) begin
         req_valid_a = rv; restart_a = rs; xfer = rv && req_ready_a && !rs;
      end else begin
         req_valid_b = rv; restart_b = rs; xfer = rv && req_ready_b && !rs;
      end
      if (xfer) begin
         next_exp(w, e);
         if (w == 0) q_a.push_back(e);
         else        q_b.push_back(e);
      end
      if (rs) begin
         m_blk[w]   = '0;
         m_off[w]   = 0;
         m_nonce[w] = (w == 0) ? nonce_a : nonce_b;
         m_key[w]   = (w == 0) ? key_a : key_b;
      end
      @(negedge clk);
      if (w == 0) begin
         req_valid_a = 1'b0; restart_a = 1'b0; vld = ks_valid_a; got = 64'(ks_data_a);
      end else begin
         req_valid_b = 1'b0; restart_b = 1'b0; vld = ks_valid_b; got = 64'(ks_data_b);
      end
      check($sformatf("ks_valid%0d", w), 64'(vld), 64'(xfer));
      if (vld && xfer) begin
         if (w == 0) e = q_a.pop_front();
         else        e = q_b.pop_front();
         last_exp[w] = e;
         check($sformatf("ks_data%0d", w), got, e);
      end
   endtask

   task automatic idle(input int w, input int n);
      bit x;
      for (int i = 0; i < n; i++) cyc(w, 1'b0, 1'b0, x);
   endtask

   task automatic wait_ready(input int w, input int budget, output int n);
      bit x;
      n = 0;
      while ((((w == 0) ? req_ready_a : req_ready_b) !== 1'b1) && n < budget) begin
         cyc(w, 1'b0, 1'b0, x);
         n++;
      end
   endtask

   task automatic read_n(input int w, input int cnt, input int budget);
      bit x;
      int t, c;
      t = 0;
      c = 0;
      while (t < cnt && c < budget) begin
         cyc(w, 1'b1, 1'b0, x);
         if (x) t++;
         c++;
      end
      check($sformatf("reads%0d", w), 64'(t), 64'(cnt));
   endtask

   initial begin
      bit x;
      int n, t;
      logic [63:0] blk;
      for (int i = 0; i < 2; i++) begin
         m_nonce[i] = '0; m_blk[i] = '0; m_key[i] = '0; m_off[i] = 0; last_exp[i] = '0;
      end

      // Reset state
      @(negedge clk);
      check("rst_a", {req_ready_a, ks_valid_a, ctr_wrapped_a, busy_a, blocks_done_a, ks_data_a}, 64'd0);
      check("rst_b", {req_ready_b, ks_valid_b, ctr_wrapped_b, busy_b, blocks_done_b, ks_data_b}, 64'd0);
      nrst = 1'b1;
      idle(0, 3);

      // Default latency and eight single-byte reads of E_0({0,0})
      cyc(0, 1'b0, 1'b1, x);
      wait_ready(0, 60, n);
      check("lat_a", 64'(n + 1), 64'd35);
      read_n(0, 8, 8);
      idle(0, 1);
      check("hold_a", 64'(ks_data_a), last_exp[0]);

      // Prefetch fill, idle, refill after one block drained
      cyc(0, 1'b0, 1'b1, x);
      idle(0, 100);
      check("fill_busy", 64'(busy_a), 64'd0);
      check("fill_done", blocks_done_a, 64'd2);
      idle(0, 20);
      check("fill_stay", blocks_done_a, 64'd2);
      read_n(0, 8, 8);
      check("pop_busy0", 64'(busy_a), 64'd0);
      idle(0, 1);
      check("pop_busy1", 64'(busy_a), 64'd1);
      idle(0, 33);
      check("refill_pre", blocks_done_a, 64'd2);
      idle(0, 1);
      check("refill", blocks_done_a, 64'd3);

      // Counter wrap with ctr preloaded to all-ones
      nonce_a = 32'hA5A5_0001;
      key_a   = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
      cyc(0, 1'b0, 1'b1, x);
      force dut_a.ctr_reg = 32'hFFFF_FFFF;
      m_blk[0] = 32'hFFFF_FFFF;
      idle(0, 1);
      release dut_a.ctr_reg;
      check("wrap_pre", 64'(ctr_wrapped_a), 64'd0);
      n = 0;
      while (blocks_done_a != 32'd1 && n < 60) begin idle(0, 1); n++; end
      check("wrap_flag", 64'(ctr_wrapped_a), 64'd1);
      check("wrap_ctr", 64'(dut_a.ctr_reg), 64'd0);
      read_n(0, 16, 200);

      // Restart mid-ROUND with a request in the same cycle
      nonce_a = 32'h0BAD_BEEF;
      cyc(0, 1'b0, 1'b1, x);
      check("wrap_clr", 64'(ctr_wrapped_a), 64'd0);
      wait_ready(0, 60, n);
      idle(0, 5);
      nonce_a = 32'h1357_9BDF;
      cyc(0, 1'b1, 1'b1, x);
      check("rs_ready", 64'(req_ready_a), 64'd0);
      check("rs_blocks", blocks_done_a, 64'd0);
      wait_ready(0, 60, n);
      check("rs_lat", 64'(n + 1), 64'd35);
      read_n(0, 8, 8);

      // Wide, unrolled instance: latency, halves, depth-1 fill
      key_b   = 128'h00010203_04050607_08090A0B_0C0D0E0F;
      nonce_b = 32'h1234_5678;
      cyc(1, 1'b0, 1'b1, x);
      wait_ready(1, 30, n);
      check("lat_b", 64'(n + 1), 64'd11);
      idle(1, 3);
      check("full_b", blocks_done_b, 64'd1);
      check("idle_b", 64'(busy_b), 64'd0);
      blk = xtea_blk(32'h1234_5678, 32'd0, key_b);
      cyc(1, 1'b1, 1'b0, x);
      check("v1_b", 64'(ks_data_b), 64'(blk[31:0]));
      cyc(1, 1'b1, 1'b0, x);
      check("v0_b", 64'(ks_data_b), 64'(blk[63:32]));

      // Back-to-back requests across three blocks
      cyc(1, 1'b0, 1'b1, x);
      wait_ready(1, 30, n);
      t = 0;
      n = 0;
      while (t < 6 && n < 100) begin
         cyc(1, 1'b1, 1'b0, x);
         if (x) begin
            t++;
            if (m_off[1] == 0) check("ready_drop", 64'(req_ready_b), 64'd0);
         end
         n++;
      end
      check("b2b_count", 64'(t), 64'd6);
      check("b2b_blocks", blocks_done_b, 64'd3);

      // Asynchronous reset mid-stream
      req_valid_b = 1'b1;
      #2 nrst = 1'b0;
      #1;
      check("arst_a", {req_ready_a, ks_valid_a, ctr_wrapped_a, busy_a, blocks_done_a, ks_data_a}, 64'd0);
      check("arst_b", {req_ready_b, ks_valid_b, ctr_wrapped_b, busy_b, blocks_done_b, ks_data_b}, 64'd0);
      req_valid_b = 1'b0;
      @(negedge clk);
      nrst = 1'b1;
      check("sb_empty", 64'(q_a.size() + q_b.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
